// File: rtl/unum4_arb_pkg.sv
// Shared constants and types for the unum4 FPU arbiter.
package unum4_arb_pkg;

  // FPU opcodes; the arbiter forwards them untouched
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  // Arbiter control states
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  // Bit positions inside resp_flags
  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_DBZ = 2;
  localparam int FLG_ERR = 3;

endpackage

// File: rtl/unum4_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module unum4_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             found
);

  // Walk N_REQ positions starting at ptr; the first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        found                         = 1'b1;
        gnt[(int'(ptr) + k) % N_REQ]  = 1'b1;
        gnt_idx                       = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/unum4_fpu_arbiter.sv
// Round-robin sharing of one unum4 FPU among N_REQ requesters, one op in flight.
// Optional watchdog in WAIT: define UNUM4_ARB_TIMEOUT_EN.
module unum4_fpu_arbiter
  import unum4_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int OPCODE_W    = 2,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0]       req_in0,
  input  logic [N_REQ-1:0][DATA_W-1:0]       req_in1,
  input  logic [N_REQ-1:0][OPCODE_W-1:0]     req_op,
  output logic [N_REQ-1:0]                   resp_valid,
  output logic [DATA_W-1:0]                  resp_data,
  output logic [3:0]                         resp_flags,
  output logic                               busy,
  output logic                               fpu_run,
  output logic [DATA_W-1:0]                  fpu_in0,
  output logic [DATA_W-1:0]                  fpu_in1,
  output logic [OPCODE_W-1:0]                fpu_op,
  input  logic [DATA_W-1:0]                  fpu_out,
  input  logic                               fpu_done,
  input  logic                               fpu_overflow,
  input  logic                               fpu_underflow,
  input  logic                               fpu_div_by_zero
);

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   ptr, gnt_idx, pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic              pick_any;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        res_flags, done_flags;
  logic              tmo_hit;

  unum4_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx),
    .found   (pick_any)
  );

`ifdef UNUM4_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Cycles spent in WAIT for the current op; cleared everywhere else
  always_ff @(posedge clk) begin
    if (!rst)               tmo_cnt <= '0;
    else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    else                    tmo_cnt <= '0;
  end

  assign tmo_hit = (state == WAIT) && !fpu_done && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: this term is constant false
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  // Pack FPU status into the response flag layout; err only comes from the watchdog
  always_comb begin
    done_flags          = '0;
    done_flags[FLG_OVF] = fpu_overflow;
    done_flags[FLG_UNF] = fpu_underflow;
    done_flags[FLG_DBZ] = fpu_div_by_zero;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and per-state strobes; done outside WAIT is ignored
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    fpu_run    = 1'b0;
    resp_valid = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (pick_any && rst) begin
               req_ready = pick_oh;
               state_nxt = ISSUE;
             end
      ISSUE: begin
               fpu_run   = 1'b1;
               state_nxt = WAIT;
             end
      WAIT:  if (fpu_done || tmo_hit) state_nxt = RESP;
      RESP:  begin
               resp_valid = N_REQ'(1) << gnt_idx;
               state_nxt  = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on grant, result capture on done/timeout, pointer advance on response
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      gnt_idx   <= '0;
      fpu_in0   <= '0;
      fpu_in1   <= '0;
      fpu_op    <= '0;
      res_data  <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
                gnt_idx <= pick_idx;
                fpu_in0 <= req_in0[pick_idx];
                fpu_in1 <= req_in1[pick_idx];
                fpu_op  <= req_op[pick_idx];
              end
        WAIT: if (fpu_done) begin
                res_data  <= fpu_out;
                res_flags <= done_flags;
              end else if (tmo_hit) begin
                res_data  <= '0;
                res_flags <= 4'b1000;
              end
        RESP: ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign resp_data  = res_data;
  assign resp_flags = res_flags;

endmodule
